// File: rtl/sub_max_stage.sv
// ---------------------------------------------------------------------------
// sub_max_stage
//
// Softmax stage that sits directly downstream of max_tree_block. It captures
// the same serial element stream that feeds the max tree, waits for the max
// result, then replays every element as (x_i - max) to the exponent stage
// over a valid/ready handshake. Every value sent downstream is therefore
// <= 0, unless the subtraction overflows (see below).
//
// Optional feature macro: SUB_MAX_SAT_EN
//   defined   : an out-of-range difference saturates to the most negative or
//               the most positive data_size-bit value
//   undefined : an out-of-range difference wraps (low data_size bits kept)
//   In-range results are the same in both builds.
//
// Parameters
//   data_size       width of each signed two's-complement word
//   number_of_data  elements per softmax vector (>= 2)
//
// Ports
//   clock_i          single clock, rising edge
//   reset_i          synchronous, active-high reset (aborts any frame)
//   start_i          data_i valid this cycle (same timing as the max tree input)
//   data_i           signed input element
//   data_max_i       signed max from max_tree_block
//   max_tree_done_i  one-cycle pulse, data_max_i valid
//   ready_i          downstream accepts data_sub_o
//   data_sub_o       signed x_i - max
//   valid_o          data_sub_o valid
//   last_o           high while element number_of_data-1 is presented
//   sub_done_o       one-cycle pulse after the last transfer
//   busy_o           high in every state except IDLE
// ---------------------------------------------------------------------------
module sub_max_stage #(
  parameter int data_size      = 32,
  parameter int number_of_data = 10
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic signed [data_size-1:0] data_i,
  input  logic signed [data_size-1:0] data_max_i,
  input  logic                        max_tree_done_i,
  input  logic                        ready_i,
  output logic signed [data_size-1:0] data_sub_o,
  output logic                        valid_o,
  output logic                        last_o,
  output logic                        sub_done_o,
  output logic                        busy_o
);

  localparam int CNT_W = (number_of_data > 1) ? $clog2(number_of_data) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(number_of_data - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_MAX = 3'd2,
    EMIT     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state, state_next;

  logic signed [data_size-1:0] data_buf [number_of_data];
  logic [CNT_W-1:0]            wr_cnt;
  logic [CNT_W-1:0]            rd_cnt;
  logic [CNT_W-1:0]            wr_idx;
  logic [CNT_W-1:0]            rd_next;
  logic [CNT_W-1:0]            sub_idx;
  logic signed [data_size-1:0] max_reg;
  logic                        max_valid;
  logic signed [data_size-1:0] max_eff;
  logic signed [data_size-1:0] sub_in_p0;
  logic signed [data_size-1:0] diff_p0;

  logic wr_en;
  logic max_capture;
  logic emit_start;
  logic emit_adv;
  logic emit_end;
  logic xfer;

  // Narrow a data_size+1-bit difference back to data_size bits. An overflow
  // is visible as a disagreement between the two top bits of the wide result.
  function automatic logic signed [data_size-1:0] sat_fn(
    input logic signed [data_size:0] d
  );
`ifdef SUB_MAX_SAT_EN
    if (d[data_size] != d[data_size-1]) begin
      if (d[data_size])
        sat_fn = {1'b1, {(data_size-1){1'b0}}};
      else
        sat_fn = {1'b0, {(data_size-1){1'b1}}};
    end else begin
      sat_fn = d[data_size-1:0];
    end
`else
    sat_fn = d[data_size-1:0];
`endif
  endfunction

  // Full-precision x - max: sign-extend both operands by one bit so the
  // subtraction itself can never overflow.
  function automatic logic signed [data_size-1:0] sub_fn(
    input logic signed [data_size-1:0] x,
    input logic signed [data_size-1:0] m
  );
    logic signed [data_size:0] d;
    d      = {x[data_size-1], x} - {m[data_size-1], m};
    sub_fn = sat_fn(d);
  endfunction

  assign xfer   = valid_o & ready_i;
  assign busy_o = (state != IDLE);

  // The first element of a frame always lands at index 0, whatever wr_cnt
  // was left at by a previous or aborted frame.
  assign wr_idx  = (state == IDLE) ? '0 : wr_cnt;
  assign rd_next = rd_cnt + 1'b1;

  // A max pulse in the very cycle WAIT_MAX resolves is used directly, since
  // max_reg only picks it up on the same edge.
  assign max_eff = max_valid ? max_reg : data_max_i;

  always_comb begin
    state_next  = state;
    wr_en       = 1'b0;
    emit_start  = 1'b0;
    emit_adv    = 1'b0;
    emit_end    = 1'b0;
    max_capture = !max_valid && max_tree_done_i &&
                  ((state == LOAD) || (state == WAIT_MAX));
    case (state)
      IDLE: begin
        if (start_i) begin
          wr_en      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (start_i) begin
          wr_en = 1'b1;
          if (wr_cnt == LAST_IDX)
            state_next = WAIT_MAX;
        end
      end
      WAIT_MAX: begin
        if (max_valid || max_tree_done_i) begin
          emit_start = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (last_o) begin
            emit_end   = 1'b1;
            state_next = DONE;
          end else begin
            emit_adv = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    sub_idx   = emit_start ? '0 : rd_next;
    sub_in_p0 = data_buf[sub_idx];
    diff_p0   = sub_fn(sub_in_p0, max_eff);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clock_i) begin
    if (wr_en)
      data_buf[wr_idx] <= data_i;
    if (max_capture)
      max_reg <= data_max_i;
  end

  // ---- output stage: difference registered alongside valid/last ----
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      max_valid  <= 1'b0;
      data_sub_o <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      sub_done_o <= 1'b0;
    end else begin
      sub_done_o <= emit_end;

      if (wr_en)
        wr_cnt <= wr_idx + 1'b1;
      else if (state == DONE)
        wr_cnt <= '0;

      if (max_capture)
        max_valid <= 1'b1;
      else if (state == DONE)
        max_valid <= 1'b0;

      if (emit_start) begin
        rd_cnt     <= '0;
        data_sub_o <= diff_p0;
        valid_o    <= 1'b1;
        last_o     <= 1'b0;
      end else if (emit_adv) begin
        rd_cnt     <= rd_next;
        data_sub_o <= diff_p0;
        last_o     <= (rd_next == LAST_IDX);
      end else if (emit_end) begin
        rd_cnt  <= '0;
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sub_max_stage.sv
// ---------------------------------------------------------------------------
// tb_sub_max_stage
//
// Directed bench for sub_max_stage (data_size=32, number_of_data=10).
// Each scenario task drives its own stimulus and checks results inline.
// ---------------------------------------------------------------------------
module tb_sub_max_stage;

  localparam int DW = 32;
  localparam int N  = 10;

  typedef logic signed [DW-1:0] frame_t [N];

  logic                 clock;
  logic                 reset_i;
  logic                 start_i;
  logic signed [DW-1:0] data_i;
  logic signed [DW-1:0] data_max_i;
  logic                 max_tree_done_i;
  logic                 ready_i;
  logic signed [DW-1:0] data_sub_o;
  logic                 valid_o;
  logic                 last_o;
  logic                 sub_done_o;
  logic                 busy_o;

  int tests_run;
  int tests_failed;

  // results gathered by collect()
  logic signed [DW-1:0] got [N];
  int got_n;
  int hold_bad;
  int last_bad;
  int done_ok;
  int span;

  frame_t nom_in;
  frame_t nom_exp;

  sub_max_stage #(
    .data_size      (DW),
    .number_of_data (N)
  ) dut (
    .clock_i         (clock),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .data_i          (data_i),
    .data_max_i      (data_max_i),
    .max_tree_done_i (max_tree_done_i),
    .ready_i         (ready_i),
    .data_sub_o      (data_sub_o),
    .valid_o         (valid_o),
    .last_o          (last_o),
    .sub_done_o      (sub_done_o),
    .busy_o          (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Stream a frame. A gap of two idle cycles follows element gap_after.
  // Max pulses may ride along with element max_at and/or max2_at.
  task automatic load_frame(input frame_t d, input int gap_after,
                            input int max_at, input logic signed [DW-1:0] maxv,
                            input int max2_at, input logic signed [DW-1:0] max2v);
    for (int i = 0; i < N; i++) begin
      start_i         = 1'b1;
      data_i          = d[i];
      max_tree_done_i = (i == max_at) || (i == max2_at);
      data_max_i      = (i == max2_at) ? max2v : maxv;
      tick();
      start_i         = 1'b0;
      max_tree_done_i = 1'b0;
      if (i == gap_after) begin
        tick();
        tick();
      end
    end
  endtask

  task automatic pulse_max(input logic signed [DW-1:0] maxv);
    max_tree_done_i = 1'b1;
    data_max_i      = maxv;
    tick();
    max_tree_done_i = 1'b0;
  endtask

  // Drain one frame. mode 0: ready always high; mode 1: ready 1,0,0,1,0,0...
  // noise drives start_i high during the drain.
  task automatic collect(input int mode, input bit noise);
    logic signed [DW-1:0] pd;
    logic                 pl;
    bit                   held;
    int                   first_c;
    got_n    = 0;
    hold_bad = 0;
    last_bad = 0;
    done_ok  = 0;
    span     = -1;
    held     = 0;
    first_c  = -1;
    pd       = '0;
    pl       = 1'b0;
    for (int c = 0; c < 300 && got_n < N; c++) begin
      ready_i = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      if (noise) begin
        start_i = 1'b1;
        data_i  = 32'sd1234;
      end
      if (held && (valid_o !== 1'b1 || data_sub_o !== pd || last_o !== pl))
        hold_bad++;
      held = 0;
      if (valid_o === 1'b1 && ready_i) begin
        if (first_c < 0) first_c = c;
        got[got_n] = data_sub_o;
        if (last_o !== (got_n == N - 1)) last_bad++;
        got_n++;
        span = c - first_c;
      end else if (valid_o === 1'b1) begin
        held = 1;
        pd   = data_sub_o;
        pl   = last_o;
      end
      tick();
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    if (got_n == N) begin
      done_ok = (sub_done_o === 1'b1 && valid_o === 1'b0 &&
                 last_o === 1'b0 && busy_o === 1'b1) ? 1 : 0;
      tick();
      if (sub_done_o !== 1'b0 || busy_o !== 1'b0) done_ok = 0;
    end
  endtask

  task automatic test_reset;
    reset_i         = 1'b1;
    start_i         = 1'b1;
    max_tree_done_i = 1'b1;
    data_i          = 32'sd5;
    data_max_i      = 32'sd7;
    ready_i         = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (data_sub_o !== 0 || valid_o !== 0 || last_o !== 0 ||
        sub_done_o !== 0 || busy_o !== 0) begin
      tests_failed++;
      $display("FAIL reset_outputs got data=%0d valid=%b last=%b done=%b busy=%b, expected all 0",
               data_sub_o, valid_o, last_o, sub_done_o, busy_o);
    end
    start_i         = 1'b0;
    max_tree_done_i = 1'b0;
    reset_i         = 1'b0;
    tick();
    tests_run++;
    if (busy_o !== 0 || valid_o !== 0) begin
      tests_failed++;
      $display("FAIL reset_release got busy=%b valid=%b, expected 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_nominal;
    load_frame(nom_in, -1, -1, 32'sd0, -1, 32'sd0);
    tests_run++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL nominal_wait got valid=%b busy=%b, expected 0 1", valid_o, busy_o);
    end
    pulse_max(32'sd9);
    tests_run++;
    if (valid_o !== 1'b1 || data_sub_o !== -32'sd6) begin
      tests_failed++;
      $display("FAIL nominal_latency got valid=%b data=%0d, expected 1 -6", valid_o, data_sub_o);
    end
    collect(0, 0);
    tests_run++;
    if (got_n !== N) begin
      tests_failed++;
      $display("FAIL nominal_count got %0d expected %0d", got_n, N);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got[i] !== nom_exp[i]) begin
        tests_failed++;
        $display("FAIL nominal_data[%0d] got %0d expected %0d", i, got[i], nom_exp[i]);
      end
    end
    tests_run++;
    if (span !== N - 1 || last_bad !== 0) begin
      tests_failed++;
      $display("FAIL nominal_timing got span=%0d last_errs=%0d, expected 9 0", span, last_bad);
    end
    tests_run++;
    if (done_ok !== 1) begin
      tests_failed++;
      $display("FAIL nominal_sub_done got %0d expected 1", done_ok);
    end
  endtask

  task automatic test_backpressure;
    load_frame(nom_in, -1, -1, 32'sd0, -1, 32'sd0);
    pulse_max(32'sd9);
    collect(1, 0);
    tests_run++;
    if (got_n !== N || hold_bad !== 0 || last_bad !== 0) begin
      tests_failed++;
      $display("FAIL bp_handshake got count=%0d hold_errs=%0d last_errs=%0d, expected 10 0 0",
               got_n, hold_bad, last_bad);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got[i] !== nom_exp[i]) begin
        tests_failed++;
        $display("FAIL bp_data[%0d] got %0d expected %0d", i, got[i], nom_exp[i]);
      end
    end
    tests_run++;
    if (done_ok !== 1) begin
      tests_failed++;
      $display("FAIL bp_sub_done got %0d expected 1", done_ok);
    end
  endtask

  task automatic test_gaps_early_max;
    load_frame(nom_in, 3, 6, 32'sd9, 8, 32'sd100);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_no_early_valid got %b expected 0", valid_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || data_sub_o !== -32'sd6) begin
      tests_failed++;
      $display("FAIL gap_emit_start got valid=%b data=%0d, expected 1 -6", valid_o, data_sub_o);
    end
    collect(0, 0);
    tests_run++;
    if (got_n !== N || done_ok !== 1) begin
      tests_failed++;
      $display("FAIL gap_count got count=%0d done=%0d, expected 10 1", got_n, done_ok);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got[i] !== nom_exp[i]) begin
        tests_failed++;
        $display("FAIL gap_data[%0d] got %0d expected %0d", i, got[i], nom_exp[i]);
      end
    end
  endtask

  task automatic test_overflow;
    frame_t               ov;
    logic signed [DW-1:0] e;
    logic signed [DW-1:0] ov_exp;
    longint               w;
    ov[0] = 32'sh8000_0000;
    for (int i = 1; i < N; i++) ov[i] = DW'(i - 1);
`ifdef SUB_MAX_SAT_EN
    ov_exp = 32'sh8000_0000;
`else
    ov_exp = 32'sh0000_0001;
`endif
    load_frame(ov, -1, -1, 32'sd0, -1, 32'sd0);
    pulse_max(32'sh7FFF_FFFF);
    collect(0, 0);
    tests_run++;
    if (got_n !== N || got[0] !== ov_exp) begin
      tests_failed++;
      $display("FAIL overflow_elem0 got count=%0d data=%h, expected 10 %h", got_n, got[0], ov_exp);
    end
    for (int i = 1; i < N; i++) begin
      w = longint'(i - 1) - 64'sd2147483647;
      e = w[DW-1:0];
      tests_run++;
      if (got[i] !== e) begin
        tests_failed++;
        $display("FAIL overflow_inrange[%0d] got %0d expected %0d", i, got[i], e);
      end
    end
  endtask

  task automatic test_back_to_back;
    frame_t f2;
    for (int i = 0; i < N; i++) f2[i] = DW'(10 * (i + 1));
    load_frame(nom_in, -1, -1, 32'sd0, -1, 32'sd0);
    pulse_max(32'sd9);
    collect(0, 1);
    tests_run++;
    if (got_n !== N || done_ok !== 1) begin
      tests_failed++;
      $display("FAIL b2b_frame1_count got count=%0d done=%0d, expected 10 1", got_n, done_ok);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got[i] !== nom_exp[i]) begin
        tests_failed++;
        $display("FAIL b2b_frame1[%0d] got %0d expected %0d", i, got[i], nom_exp[i]);
      end
    end
    // Frame 2 starts right away; the max arrives with the last element.
    load_frame(f2, -1, 9, 32'sd100, -1, 32'sd0);
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_frame2_wait got valid=%b expected 0", valid_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || data_sub_o !== -32'sd90) begin
      tests_failed++;
      $display("FAIL b2b_frame2_start got valid=%b data=%0d, expected 1 -90", valid_o, data_sub_o);
    end
    collect(0, 0);
    tests_run++;
    if (got_n !== N || done_ok !== 1) begin
      tests_failed++;
      $display("FAIL b2b_frame2_count got count=%0d done=%0d, expected 10 1", got_n, done_ok);
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (got[i] !== DW'(10 * (i + 1) - 100)) begin
        tests_failed++;
        $display("FAIL b2b_frame2[%0d] got %0d expected %0d", i, got[i], 10 * (i + 1) - 100);
      end
    end
  endtask

  task automatic test_reset_mid_emit;
    int stray;
    frame_t f2;
    for (int i = 0; i < N; i++) f2[i] = DW'(10 * (i + 1));
    load_frame(nom_in, -1, -1, 32'sd0, -1, 32'sd0);
    pulse_max(32'sd9);
    ready_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    tests_run++;
    if (valid_o !== 0 || busy_o !== 0 || last_o !== 0 ||
        sub_done_o !== 0 || data_sub_o !== 0) begin
      tests_failed++;
      $display("FAIL midreset_outputs got valid=%b busy=%b last=%b done=%b data=%0d, expected all 0",
               valid_o, busy_o, last_o, sub_done_o, data_sub_o);
    end
    stray = 0;
    for (int c = 0; c < 15; c++) begin
      if (sub_done_o !== 0 || valid_o !== 0 || busy_o !== 0) stray++;
      tick();
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL midreset_quiet got %0d active cycles expected 0", stray);
    end
    load_frame(f2, -1, 9, 32'sd100, -1, 32'sd0);
    tick();
    collect(0, 0);
    tests_run++;
    if (got_n !== N || got[0] !== -32'sd90 || got[N-1] !== 32'sd0 || done_ok !== 1) begin
      tests_failed++;
      $display("FAIL midreset_recover got count=%0d first=%0d last=%0d done=%0d, expected 10 -90 0 1",
               got_n, got[0], got[N-1], done_ok);
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset_i         = 1'b1;
    start_i         = 1'b0;
    data_i          = '0;
    data_max_i      = '0;
    max_tree_done_i = 1'b0;
    ready_i         = 1'b1;
    nom_in  = '{32'sd3, -32'sd7, 32'sd9, 32'sd0, -32'sd10,
                32'sd5, 32'sd9, -32'sd1, 32'sd2, -32'sd3};
    nom_exp = '{-32'sd6, -32'sd16, 32'sd0, -32'sd9, -32'sd19,
                -32'sd4, 32'sd0, -32'sd10, -32'sd7, -32'sd12};

    test_reset();
    test_nominal();
    test_backpressure();
    test_gaps_early_max();
    test_overflow();
    test_back_to_back();
    test_reset_mid_emit();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
